// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiply uses shift-add into a 64-bit unsigned product. Divide uses the restoring
// method and produces one quotient bit per cycle. Both work on operand magnitudes,
// and the sign is fixed up in a final cycle. Divide-by-zero and signed overflow
// skip the iteration and complete directly.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1Data,
  input  logic [XLEN-1:0]  rs2Data,
  input  logic [4:0]       rdIn,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [4:0]       rdOut,
  output logic             wrEn
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           f3_q, f3_d;
  logic [4:0]           rd_q, rd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {hi, lo} where lo starts as the multiplier.
  // Divide: the low half holds the dividend as it shifts into the quotient.
  logic [2*XLEN-1:0]    prod_q, prod_d;
  logic [XLEN-1:0]      opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]      rem_q, rem_d;   // partial remainder
  logic                 sign_q, sign_d; // product / quotient sign
  logic                 rsign_q, rsign_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wr_en_q, wr_en_d;

  // Operand decode and datapath step values
  logic                 a_signed, b_signed, s_a, s_b;
  logic [XLEN-1:0]      mag_a, mag_b;
  logic                 div_zero, div_ovf;
  logic [XLEN:0]        mul_sum;
  logic [XLEN:0]        div_shift;
  logic [XLEN:0]        div_diff;
  logic [2*XLEN-1:0]    prod_fixed;
  logic [XLEN-1:0]      quo_fixed, rem_fixed;
  logic [XLEN-1:0]      fix_res;

  // Operand sign handling, special-case detection and one iteration of each algorithm
  always_comb begin
    a_signed   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    s_a        = a_signed && rs1Data[XLEN-1];
    s_b        = b_signed && rs2Data[XLEN-1];
    mag_a      = s_a ? (XLEN'(0) - rs1Data) : rs1Data;
    mag_b      = s_b ? (XLEN'(0) - rs2Data) : rs2Data;
    div_zero   = funct3[2] && (rs2Data == '0);
    div_ovf    = funct3[2] && !funct3[0] &&
                 (rs1Data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2Data == '1);

    mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                 {1'b0, (prod_q[0] ? opb_q : {XLEN{1'b0}})};
    div_shift  = {rem_q, prod_q[XLEN-1]};
    div_diff   = div_shift - {1'b0, opb_q};

    prod_fixed = sign_q ? ((2*XLEN)'(0) - prod_q) : prod_q;
    quo_fixed  = sign_q ? (XLEN'(0) - prod_q[XLEN-1:0]) : prod_q[XLEN-1:0];
    rem_fixed  = rsign_q ? (XLEN'(0) - rem_q) : rem_q;

    if (f3_q[2])
      fix_res = f3_q[1] ? rem_fixed : quo_fixed;
    else if (f3_q[1:0] == 2'b00)
      fix_res = prod_fixed[XLEN-1:0];
    else
      fix_res = prod_fixed[2*XLEN-1:XLEN];
  end

  // Next-state and next-output logic. Outputs are derived from the next state,
  // so busy/done/wrEn come straight from flops.
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opb_d    = opb_q;
    rem_d    = rem_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d    = funct3;
          rd_d    = rdIn;
          cnt_d   = '0;
          sign_d  = s_a ^ s_b;
          rsign_d = s_a;
          rem_d   = '0;
          if (funct3[2]) begin
            prod_d = {{XLEN{1'b0}}, mag_a};
            opb_d  = mag_b;
          end else begin
            prod_d = {{XLEN{1'b0}}, mag_b};
            opb_d  = mag_a;
          end
          if (div_zero) begin
            result_d = funct3[1] ? rs1Data : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (f3_q[2]) begin
          if (!div_diff[XLEN]) begin
            rem_d  = div_diff[XLEN-1:0];
            prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d  = div_shift[XLEN-1:0];
            prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], 1'b0};
          end
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN-1))
          state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    wr_en_d = done_d && (rd_d != '0);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_en_q  <= wr_en_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign wrEn   = wr_en_q;
  assign result = result_q;
  assign rdOut  = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [4:0]  rdIn;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rdOut;
  logic        wrEn;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct3  (funct3),
    .rs1Data (rs1Data),
    .rs2Data (rs2Data),
    .rdIn    (rdIn),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rdOut   (rdOut),
    .wrEn    (wrEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // RV32M semantics computed with wide integer arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, ub, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one operation starting in the current cycle (called just after a
  // falling edge) and follow it until the cycle after its expected done.
  // poke > 0 pulses start again in that cycle; it must be ignored.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int poke);
    logic [31:0] exp_res;
    bit          fast;
    int          exp_cyc, done_cyc, ndone;
    bit          busy_bad, stray_wr, idle_bad;
    logic [31:0] got_res;
    logic [4:0]  got_rd;
    logic        got_wr;
    exp_res  = ref_op(f, a, b);
    fast     = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_cyc  = fast ? 1 : 34;
    done_cyc = -1;
    ndone    = 0;
    busy_bad = 0;
    stray_wr = 0;
    idle_bad = 0;
    got_res  = '0;
    got_rd   = '0;
    got_wr   = 1'b0;
    start = 1'b1; funct3 = f; rs1Data = a; rs2Data = b; rdIn = rd;
    for (int cyc = 1; cyc <= exp_cyc + 1; cyc++) begin
      @(negedge clk);
      start   = (cyc == poke);
      funct3  = 3'($urandom);
      rs1Data = $urandom;
      rs2Data = $urandom;
      rdIn    = 5'($urandom);
      if (cyc <= exp_cyc && !busy) busy_bad = 1;
      if (cyc > exp_cyc && (busy || done)) idle_bad = 1;
      if (wrEn && !done) stray_wr = 1;
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          got_res  = result;
          got_rd   = rdOut;
          got_wr   = wrEn;
        end
      end
    end
    start = 1'b0;
    check({name, " done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    check({name, " done_count"}, 64'(ndone), 64'd1);
    check({name, " busy_span"}, {63'd0, busy_bad}, 64'd0);
    check({name, " idle_after"}, {63'd0, idle_bad}, 64'd0);
    check({name, " stray_wr"}, {63'd0, stray_wr}, 64'd0);
    check({name, " result"}, {32'd0, got_res}, {32'd0, exp_res});
    check({name, " rdOut"}, {59'd0, got_rd}, {59'd0, rd});
    check({name, " wrEn"}, {63'd0, got_wr}, {63'd0, (rd != 0)});
    check({name, " result_hold"}, {32'd0, result}, {32'd0, exp_res});
  endtask

  initial begin
    logic [31:0] pool [6];
    logic [31:0] ra, rb;
    int          nd;
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h2;
    reset = 1'b0; start = 1'b0; funct3 = '0; rs1Data = '0; rs2Data = '0; rdIn = '0;
    repeat (3) @(negedge clk);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst wrEn", {63'd0, wrEn}, 64'd0);
    check("rst result", {32'd0, result}, 64'd0);
    check("rst rdOut", {59'd0, rdOut}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  0);
    run_op("mulhu_ff",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  0);
    run_op("mulh_ff",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  0);
    run_op("mulhsu_ff",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  0);
    run_op("mul_min_2",   3'd0, 32'h8000_0000,  32'd2,         5'd4,  0);
    run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd6,  0);
    run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd7,  0);
    run_op("divu_100_7",  3'd5, 32'd100,        32'd7,         5'd8,  0);
    run_op("remu_100_7",  3'd7, 32'd100,        32'd7,         5'd9,  0);
    run_op("divu_5_0",    3'd5, 32'd5,          32'd0,         5'd10, 0);
    run_op("rem_5_0",     3'd6, 32'd5,          32'd0,         5'd11, 0);
    run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 0);
    run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 0);
    run_op("mul_poke20",  3'd0, 32'd123,        32'd456,       5'd14, 20);
    run_op("mul_rd0",     3'd0, 32'd3,          32'd9,         5'd0,  0);
    run_op("fast_poke1",  3'd5, 32'd9,          32'd0,         5'd15, 1);

    // Reset in cycle 10 of a DIV aborts without write-back
    start = 1'b1; funct3 = 3'd4; rs1Data = 32'd1000; rs2Data = 32'd3; rdIn = 5'd9;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort wrEn", {63'd0, wrEn}, 64'd0);
    check("abort result", {32'd0, result}, 64'd0);
    reset = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || wrEn || busy) nd++;
    end
    check("abort no_wb", 64'(nd), 64'd0);

    // Randomized operations with occasional boundary operands and ignored starts
    for (int i = 0; i < 120; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(1, 31);
      run_op($sformatf("rnd%0d", i), 3'($urandom), ra, rb, 5'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
